regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port arbiter and sequencer for the 16 x 32-bit register file. It shares the file's single write port (we3/wa3/wd3) between two writeback sources, the ALU path and the memory/load path. It uses round-robin arbitration with valid/ready handshakes and a registered output stage. Writes addressed to r15 are diverted to a separate PC-write port, because r15 reads are served from the PC and never from the array.

## Interface
Parameters:
- DATA_W, 32, data width of writeback values and register file entries
- ADDR_W, 4, register address width (16 registers; address 15 = PC)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU writeback value
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid  in  1  memory/load writeback request
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load writeback value
- mem_ready  out  1  memory request accepted this cycle (combinational)
- we3  out  1  register file write enable (registered)
- wa3  out  ADDR_W  register file write address (registered)
- wd3  out  DATA_W  register file write data (registered)
- pc_we  out  1  PC write enable, asserted for r15 destinations (registered)
- pc_wd  out  DATA_W  PC write value (registered)
- wr_pending  out  16  one-hot of the register being written this cycle (we3 or pc_we); used for hazard/bypass detection
- stall  out  1  some valid request was not accepted this cycle (combinational)

## Operation
- Requester handshake: a request is accepted on a cycle with valid=1 and ready=1. Once valid is raised, the requester holds valid, addr and data stable until accepted.
- At most one request is accepted per cycle. ready depends only on the two valid inputs and the arbiter state; it never depends on ready.
- Arbitration:
  - One valid request: it is granted.
  - Both valid: the source not granted most recently wins.
  - The last_grant state bit updates only on an accepted request.
- Accepted request is loaded into the output stage:
  - addr != 15: we3=1, wa3=addr, wd3=data, pc_we=0.
  - addr == 15: pc_we=1, pc_wd=data, we3=0. wa3/wd3 hold their previous values.
- Output stage with no acceptance: we3=0 and pc_we=0. Address and data regs hold their values.
- wr_pending: bit[wa3] set when we3=1, bit[15] set when pc_we=1, otherwise all zero. It is derived from registered state.
- stall = (alu_valid & !alu_ready) | (mem_valid & !mem_ready).
- Same destination address from both sources in the same cycle: the arbitration winner is written first and the loser follows one cycle later, so the loser's value ends up in the register. No merging or dropping.
- Starvation bound: a continuously valid request is accepted within 2 cycles.

## Timing
- Latency: acceptance on edge N, so we3/pc_we are high for exactly the cycle after edge N and the register file captures the value on edge N+1.
- Throughput: one write per cycle sustained, including alternating sources under continuous contention.
- Reset (synchronous, highest priority):
  - we3=0, pc_we=0, wa3=0, wd3=0, pc_wd=0, wr_pending=0.
  - last_grant=MEM, so ALU wins the first tie.
  - While reset=1, alu_ready=0 and mem_ready=0, and stall reflects the valid inputs.
- Reset mid-operation: an output-stage write loaded on the edge where reset=1 is discarded, so no we3/pc_we pulse follows.
- Requests presented during reset must be re-held by the source. They are accepted on the first cycle after reset deasserts.

## Test plan
- Reset then single ALU write: alu_valid=1, addr=3, data=0xDEADBEEF.
  - Required: alu_ready=1 the same cycle.
  - Next cycle: we3=1, wa3=3, wd3=0xDEADBEEF, wr_pending=0x0008, pc_we=0.
- Contention right after reset: both valid, alu addr=1 data=0x11, mem addr=2 data=0x22.
  - Required: ALU granted first, MEM in the following cycle.
  - we3 pulses in two consecutive cycles: wa3=1 then wa3=2. stall=1 only in the first cycle.
- Sustained contention over 6 cycles with both sources always valid.
  - Required: grants alternate ALU, MEM, ALU, MEM, ALU, MEM; we3=1 every cycle after the first.
- r15 diversion: mem_valid=1, addr=15, data=0x00000100.
  - Required next cycle: pc_we=1, pc_wd=0x100, we3=0, wr_pending=0x8000.
- Same-address collision: both target r7, ALU data=0xA, MEM data=0xB, last_grant=ALU.
  - Required: MEM written first, then ALU, so the final r7 value is 0xA.
- Reset mid-operation: request accepted on the edge where reset is 1.
  - Required: no we3/pc_we pulse follows.
  - A request held valid is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and
// load writeback paths, with a registered write stage and r15 diverted to the PC.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic [15:0]       wr_pending,
    output logic              stall
);

    // Handshake: a source's request transfers on a cycle where its valid and
    // ready are both 1; the source holds valid/addr/data until that cycle, and
    // ready is a function of the valids and last_grant only.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);

    src_e              last_grant_q, last_grant_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              pc_we_q, pc_we_d;
    logic [DATA_W-1:0] pc_wd_q, pc_wd_d;

    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grant: a lone request always wins; on a tie the source that did not win
    // most recently goes first. Nothing is granted while reset is held.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                alu_ready = (last_grant_q == SRC_MEM);
                mem_ready = (last_grant_q == SRC_ALU);
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
    end

    assign accept   = alu_ready | mem_ready;
    assign sel_addr = mem_ready ? mem_addr : alu_addr;
    assign sel_data = mem_ready ? mem_data : alu_data;
    assign stall    = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

    always_comb begin
        last_grant_d = last_grant_q;
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        pc_we_d      = 1'b0;
        pc_wd_d      = pc_wd_q;
        if (alu_ready) begin
            last_grant_d = SRC_ALU;
        end else if (mem_ready) begin
            last_grant_d = SRC_MEM;
        end
        // r15 lives in the PC, so its writes never touch the array port.
        if (accept) begin
            if (sel_addr == PC_ADDR) begin
                pc_we_d = 1'b1;
                pc_wd_d = sel_data;
            end else begin
                we3_d = 1'b1;
                wa3_d = sel_addr;
                wd3_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SRC_MEM;
            we3_q        <= 1'b0;
            wa3_q        <= '0;
            wd3_q        <= '0;
            pc_we_q      <= 1'b0;
            pc_wd_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            pc_we_q      <= pc_we_d;
            pc_wd_q      <= pc_wd_d;
        end
    end

    // Hazard view is built from the registered stage only, never from inputs.
    always_comb begin
        wr_pending = '0;
        for (int i = 0; i < 16; i++) begin
            if (we3_q && (wa3_q == ADDR_W'(i))) begin
                wr_pending[i] = 1'b1;
            end
        end
        if (pc_we_q) begin
            wr_pending[15] = 1'b1;
        end
    end

    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign pc_we = pc_we_q;
    assign pc_wd = pc_wd_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: driver with a round-robin reference model feeding
// an expected-write queue, and a monitor that pops it against the output stage.
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int REC_W  = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wd;
    logic [15:0]       wr_pending;
    logic              stall;

    regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
        .wr_pending(wr_pending), .stall(stall)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [REC_W-1:0]  exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;

    // Reference model: who won most recently (1 = ALU, 2 = MEM) and the
    // architectural register file as the writes should leave it.
    int                m_last;
    logic [DATA_W-1:0] model_rf[16];
    logic [DATA_W-1:0] model_pc;
    // Register file reconstructed purely from the DUT's write port.
    logic [DATA_W-1:0] obs_rf[16];
    logic [DATA_W-1:0] obs_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: drive inputs at the falling edge, check the combinational
    // handshake against the model, and queue the write that must follow.
    task automatic step(input logic r,
                        input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                        output logic a_acc, output logic m_acc);
        int winner;
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        @(negedge clk);
        reset     = r;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        #1;
        winner = 0;
        if (!r) begin
            if (av && mv)  winner = (m_last == 1) ? 2 : 1;
            else if (av)   winner = 1;
            else if (mv)   winner = 2;
        end
        check("alu_ready", alu_ready, winner == 1);
        check("mem_ready", mem_ready, winner == 2);
        check("stall", stall, (av && winner != 1) || (mv && winner != 2));
        a_acc = (winner == 1);
        m_acc = (winner == 2);
        if (r) begin
            m_last = 2;
        end else if (winner != 0) begin
            m_last = winner;
            w_addr = (winner == 1) ? aa : ma;
            w_data = (winner == 1) ? ad : md;
            exp_q.push_back({w_addr == 4'd15, w_addr, w_data});
            if (w_addr == 4'd15) model_pc = w_data;
            else                 model_rf[w_addr] = w_data;
        end
    endtask

    // ---------------- monitor ----------------
    logic [ADDR_W-1:0] exp_wa;
    logic [DATA_W-1:0] exp_wd;
    logic [DATA_W-1:0] exp_pcwd;

    initial begin
        logic rst_e;
        logic [REC_W-1:0] rec;
        exp_wa = '0; exp_wd = '0; exp_pcwd = '0;
        forever begin
            @(posedge clk);
            rst_e = reset;
            #1;
            if (rst_e) begin
                check("rst_we3", we3, 0);
                check("rst_pc_we", pc_we, 0);
                check("rst_wa3", wa3, 0);
                check("rst_wd3", wd3, 0);
                check("rst_pc_wd", pc_wd, 0);
                check("rst_wr_pending", wr_pending, 0);
                exp_wa = '0; exp_wd = '0; exp_pcwd = '0;
            end else if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                if (rec[REC_W-1]) begin
                    check("pc_we", pc_we, 1);
                    check("pc_we_we3", we3, 0);
                    check("pc_wd", pc_wd, rec[DATA_W-1:0]);
                    check("pc_wa3_hold", wa3, exp_wa);
                    check("pc_wd3_hold", wd3, exp_wd);
                    check("pc_wr_pending", wr_pending, 16'h8000);
                    exp_pcwd = rec[DATA_W-1:0];
                end else begin
                    check("we3", we3, 1);
                    check("we3_pc_we", pc_we, 0);
                    check("wa3", wa3, rec[DATA_W +: ADDR_W]);
                    check("wd3", wd3, rec[DATA_W-1:0]);
                    check("wr_pending", wr_pending, 16'(1) << rec[DATA_W +: ADDR_W]);
                    exp_wa = rec[DATA_W +: ADDR_W];
                    exp_wd = rec[DATA_W-1:0];
                end
            end else begin
                check("idle_we3", we3, 0);
                check("idle_pc_we", pc_we, 0);
                check("idle_wr_pending", wr_pending, 0);
                check("idle_wa3", wa3, exp_wa);
                check("idle_wd3", wd3, exp_wd);
                check("idle_pc_wd", pc_wd, exp_pcwd);
            end
            if (we3)   obs_rf[wa3] = wd3;
            if (pc_we) obs_pc = pc_wd;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic a_acc, m_acc;
        logic a_pend, m_pend;
        logic [ADDR_W-1:0] a_a, m_a;
        logic [DATA_W-1:0] a_d, m_d;
        logic r;

        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        m_last = 2;
        model_pc = '0; obs_pc = '0;
        for (int i = 0; i < 16; i++) begin
            model_rf[i] = '0;
            obs_rf[i]   = '0;
        end

        // Reset, then a single ALU write to r3.
        step(1, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        step(1, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        step(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);

        // Contention right after reset: ALU first, MEM held and granted next.
        step(1, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        step(0, 1, 1, 32'h11, 1, 2, 32'h22, a_acc, m_acc);
        step(0, 0, 0, 0, 1, 2, 32'h22, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);

        // Sustained contention: grants must alternate starting with ALU.
        step(1, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        a_a = 4'd4; a_d = 32'hA000_0000; m_a = 4'd5; m_d = 32'hB000_0000;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, a_a, a_d, 1, m_a, m_d, a_acc, m_acc);
            check("alt_grant_alu", alu_ready, (i % 2) == 0);
            if (a_acc) begin a_a = a_a + 4'd1; a_d = a_d + 32'd1; end
            if (m_acc) begin m_a = m_a + 4'd1; m_d = m_d + 32'd1; end
        end
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);

        // r15 diversion.
        step(0, 0, 0, 0, 1, 15, 32'h0000_0100, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);

        // Same-address collision with last_grant = ALU: MEM first, ALU last.
        step(0, 1, 2, 32'h5, 0, 0, 0, a_acc, m_acc);
        step(0, 1, 7, 32'hA, 1, 7, 32'hB, a_acc, m_acc);
        step(0, 1, 7, 32'hA, 0, 0, 0, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        check("collision_r7", obs_rf[7], 32'hA);

        // Reset mid-operation with requests held across it.
        step(0, 1, 4, 32'h44, 0, 0, 0, a_acc, m_acc);
        step(1, 1, 6, 32'h66, 1, 9, 32'h99, a_acc, m_acc);
        step(0, 1, 6, 32'h66, 1, 9, 32'h99, a_acc, m_acc);
        check("post_reset_alu_first", a_acc, 1);
        step(0, 0, 0, 0, 1, 9, 32'h99, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);

        // Randomized traffic with hold-until-accepted sources and rare resets.
        a_pend = 1'b0; m_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_pend && $urandom_range(0, 99) < 65) begin
                a_pend = 1'b1;
                a_a = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                a_d = $urandom;
            end
            if (!m_pend && $urandom_range(0, 99) < 65) begin
                m_pend = 1'b1;
                m_a = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                m_d = $urandom;
            end
            r = ($urandom_range(0, 59) == 0);
            step(r, a_pend, a_a, a_d, m_pend, m_a, m_d, a_acc, m_acc);
            if (a_acc) a_pend = 1'b0;
            if (m_acc) m_pend = 1'b0;
        end

        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);
        step(0, 0, 0, 0, 0, 0, 0, a_acc, m_acc);

        // Final report: queue drained and architectural state agrees.
        check("queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("final_r%0d", i), obs_rf[i], model_rf[i]);
        end
        check("final_pc", obs_pc, model_pc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
